// File: rtl/regfile_write_scheduler.sv
// regfile_write_scheduler
// Shares the single register-file write port between the ALU writeback (A)
// and the load writeback (B) using a round-robin pointer. Also keeps a
// per-register busy scoreboard, so decode can stall on pending sources and
// refuse a second reservation of a register that is still in flight.
// Register 0 is hard-wired to zero. It is never reserved, never written and
// never stalls.
module regfile_write_scheduler #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 16
) (
    input  logic                     CLK,
    input  logic                     RST,

    input  logic                     rsv_valid,
    input  logic [ADDR_W-1:0]        rsv_rd,
    output logic                     rsv_ready,

    input  logic [ADDR_W-1:0]        q_rs,
    input  logic [ADDR_W-1:0]        q_rt,
    output logic                     q_stall,

    input  logic                     a_valid,
    input  logic [ADDR_W-1:0]        a_rd,
    input  logic [DATA_W-1:0]        a_data,
    output logic                     a_ready,

    input  logic                     b_valid,
    input  logic [ADDR_W-1:0]        b_rd,
    input  logic [DATA_W-1:0]        b_data,
    output logic                     b_ready,

    output logic                     RegWre,
    output logic [ADDR_W-1:0]        rd,
    output logic [DATA_W-1:0]        WriteData,
    output logic [(1<<ADDR_W)-1:0]   busy,
    output logic                     err
);

    localparam int NREG = 1 << ADDR_W;

    // Registered state
    logic                pri_q,     pri_d;      // 0: A wins a tie, 1: B wins a tie
    logic [NREG-1:0]     busy_q,    busy_d;
    logic                err_q,     err_d;
    logic                regwre_q,  regwre_d;
    logic [ADDR_W-1:0]   rd_q,      rd_d;
    logic [DATA_W-1:0]   wdata_q,   wdata_d;

    // Grant and scoreboard decode
    logic                grant_a;
    logic                grant_b;
    logic                grant;
    logic [ADDR_W-1:0]   grant_rd;
    logic [DATA_W-1:0]   grant_data;
    logic                grant_wr;      // granted write targets a real register
    logic                rsv_fire;      // reservation accepted for a real register

    // Arbitration and handshake outputs; everything is forced quiet during reset
    always_comb begin
        grant_a    = !RST && a_valid && (!b_valid || !pri_q);
        grant_b    = !RST && b_valid && (!a_valid ||  pri_q);
        grant      = grant_a || grant_b;
        grant_rd   = grant_a ? a_rd   : b_rd;
        grant_data = grant_a ? a_data : b_data;
        grant_wr   = grant && (grant_rd != '0);

        a_ready    = grant_a;
        b_ready    = grant_b;

        // A register whose clear is happening this cycle is still refused:
        // the decision uses the current busy value only.
        rsv_ready  = !RST && ((rsv_rd == '0) || !busy_q[rsv_rd]);
        rsv_fire   = rsv_valid && rsv_ready && (rsv_rd != '0);

        q_stall    = !RST && (((q_rs != '0) && busy_q[q_rs]) ||
                              ((q_rt != '0) && busy_q[q_rt]));
    end

    // Next-state for pointer, scoreboard, error flag and write port
    always_comb begin
        pri_d    = pri_q;
        busy_d   = busy_q;
        err_d    = err_q;
        regwre_d = 1'b0;
        rd_d     = rd_q;
        wdata_d  = wdata_q;

        if (grant) begin
            pri_d = grant_a;
        end

        if (grant_wr) begin
            regwre_d = 1'b1;
            rd_d     = grant_rd;
            wdata_d  = grant_data;
            busy_d[grant_rd] = 1'b0;
            if (!busy_q[grant_rd]) begin
                err_d = 1'b1;
            end
        end

        // Applied after the clear so a younger reservation of the same
        // register survives a simultaneous writeback.
        if (rsv_fire) begin
            busy_d[rsv_rd] = 1'b1;
        end

        busy_d[0] = 1'b0;
    end

    // State registers with synchronous reset. A write registered on the edge
    // before reset is still presented for its one cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pri_q    <= 1'b0;
            busy_q   <= '0;
            err_q    <= 1'b0;
            regwre_q <= 1'b0;
            rd_q     <= '0;
            wdata_q  <= '0;
        end else begin
            pri_q    <= pri_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
            regwre_q <= regwre_d;
            rd_q     <= rd_d;
            wdata_q  <= wdata_d;
        end
    end

    assign RegWre    = regwre_q;
    assign rd        = rd_q;
    assign WriteData = wdata_q;
    assign busy      = busy_q;
    assign err       = err_q;

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Directed bench for regfile_write_scheduler with hand-computed expectations.
module tb_regfile_write_scheduler;

    logic        CLK = 1'b0;
    logic        RST;
    logic        rsv_valid;
    logic [3:0]  rsv_rd;
    logic        rsv_ready;
    logic [3:0]  q_rs, q_rt;
    logic        q_stall;
    logic        a_valid;
    logic [3:0]  a_rd;
    logic [15:0] a_data;
    logic        a_ready;
    logic        b_valid;
    logic [3:0]  b_rd;
    logic [15:0] b_data;
    logic        b_ready;
    logic        RegWre;
    logic [3:0]  rd;
    logic [15:0] WriteData;
    logic [15:0] busy;
    logic        err;

    int errors = 0;
    int checks = 0;

    regfile_write_scheduler #(.ADDR_W(4), .DATA_W(16)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .rsv_valid (rsv_valid),
        .rsv_rd    (rsv_rd),
        .rsv_ready (rsv_ready),
        .q_rs      (q_rs),
        .q_rt      (q_rt),
        .q_stall   (q_stall),
        .a_valid   (a_valid),
        .a_rd      (a_rd),
        .a_data    (a_data),
        .a_ready   (a_ready),
        .b_valid   (b_valid),
        .b_rd      (b_rd),
        .b_data    (b_data),
        .b_ready   (b_ready),
        .RegWre    (RegWre),
        .rd        (rd),
        .WriteData (WriteData),
        .busy      (busy),
        .err       (err)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock and land 1 ns after the edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic reserve(input logic [3:0] r);
        rsv_valid = 1'b1;
        rsv_rd    = r;
        #1;
        chk($sformatf("rsv_ready_%0d", r), rsv_ready, 1);
        tick();
        rsv_valid = 1'b0;
    endtask

    initial begin
        RST = 1'b1;
        rsv_valid = 0; rsv_rd = 4'd3;
        q_rs = 0; q_rt = 0;
        a_valid = 0; a_rd = 0; a_data = 0;
        b_valid = 0; b_rd = 0; b_data = 0;
        tick();
        tick();
        #1;
        chk("rst_regwre", RegWre, 0);
        chk("rst_rd", rd, 0);
        chk("rst_wdata", WriteData, 0);
        chk("rst_busy", busy, 16'h0000);
        chk("rst_err", err, 0);
        chk("rst_rsv_ready", rsv_ready, 0);
        RST = 1'b0;
        tick();

        // Reserve 3, stall on it, then A writes it
        reserve(4'd3);
        chk("busy_r3", busy, 16'h0008);
        q_rs = 4'd3;
        a_valid = 1; a_rd = 4'd3; a_data = 16'h1234;
        #1;
        chk("stall_r3", q_stall, 1);
        chk("a_ready_r3", a_ready, 1);
        chk("b_ready_idle", b_ready, 0);
        tick();
        a_valid = 0;
        #1;
        chk("w3_regwre", RegWre, 1);
        chk("w3_rd", rd, 3);
        chk("w3_data", WriteData, 16'h1234);
        chk("w3_busy", busy, 16'h0000);
        chk("w3_stall", q_stall, 0);
        tick();
        chk("w3_regwre_drop", RegWre, 0);
        chk("w3_rd_hold", rd, 3);
        q_rs = 0;

        // B writes r0: handshake only, moves pointer back to A
        b_valid = 1; b_rd = 4'd0; b_data = 16'h5555;
        #1;
        chk("b0_ready", b_ready, 1);
        tick();
        b_valid = 0;
        chk("b0_regwre", RegWre, 0);
        chk("b0_err", err, 0);

        // Tie with pointer at A: A then B
        reserve(4'd1);
        reserve(4'd2);
        chk("busy_r12", busy, 16'h0006);
        a_valid = 1; a_rd = 4'd1; a_data = 16'hAAAA;
        b_valid = 1; b_rd = 4'd2; b_data = 16'hBBBB;
        #1;
        chk("tie1_a", a_ready, 1);
        chk("tie1_b", b_ready, 0);
        tick();
        a_valid = 0;
        #1;
        chk("tie1_b2", b_ready, 1);
        chk("tie1_w_rd", rd, 1);
        chk("tie1_w_data", WriteData, 16'hAAAA);
        tick();
        b_valid = 0;
        chk("tie1_w2_we", RegWre, 1);
        chk("tie1_w2_rd", rd, 2);
        chk("tie1_w2_data", WriteData, 16'hBBBB);
        chk("tie1_busy", busy, 16'h0000);

        // B grant first, then the next tie goes to A
        reserve(4'd1);
        reserve(4'd2);
        reserve(4'd4);
        b_valid = 1; b_rd = 4'd2; b_data = 16'h2222;
        #1;
        chk("bfirst_b", b_ready, 1);
        chk("bfirst_a", a_ready, 0);
        tick();
        a_valid = 1; a_rd = 4'd1; a_data = 16'h1111;
        b_rd = 4'd4; b_data = 16'h4444;
        #1;
        chk("tie2_a", a_ready, 1);
        chk("tie2_b", b_ready, 0);
        chk("tie2_w_rd", rd, 2);
        chk("tie2_w_data", WriteData, 16'h2222);
        tick();
        a_valid = 0;
        #1;
        chk("tie2_b2", b_ready, 1);
        chk("tie2_w2_rd", rd, 1);
        chk("tie2_w2_data", WriteData, 16'h1111);
        tick();
        b_valid = 0;
        chk("tie2_w3_rd", rd, 4);
        chk("tie2_w3_data", WriteData, 16'h4444);
        chk("tie2_busy", busy, 16'h0000);

        // Reservation refused while the clear is in flight, then retried
        reserve(4'd5);
        chk("busy_r5", busy, 16'h0020);
        rsv_valid = 1; rsv_rd = 4'd5;
        a_valid = 1; a_rd = 4'd5; a_data = 16'h5A5A;
        #1;
        chk("r5_refused", rsv_ready, 0);
        chk("r5_a_ready", a_ready, 1);
        tick();
        a_valid = 0;
        #1;
        chk("r5_cleared", busy, 16'h0000);
        chk("r5_retry_ready", rsv_ready, 1);
        tick();
        rsv_valid = 0;
        chk("r5_reserved", busy, 16'h0020);
        chk("r5_err", err, 0);
        a_valid = 1; a_rd = 4'd5; a_data = 16'h0005;
        tick();
        a_valid = 0;
        chk("r5_free", busy, 16'h0000);

        // Write to r0 leaves busy and RegWre alone; unreserved write flags err
        reserve(4'd6);
        a_valid = 1; a_rd = 4'd0; a_data = 16'hFFFF;
        #1;
        chk("r0_a_ready", a_ready, 1);
        tick();
        a_valid = 0;
        chk("r0_regwre", RegWre, 0);
        chk("r0_busy", busy, 16'h0040);
        chk("r0_err", err, 0);
        a_valid = 1; a_rd = 4'd9; a_data = 16'h0909;
        tick();
        a_valid = 0;
        chk("r9_err", err, 1);
        chk("r9_rd", rd, 9);
        tick();
        tick();
        chk("r9_err_sticky", err, 1);

        // Same-edge reserve and write of r7: reservation survives
        rsv_valid = 1; rsv_rd = 4'd7;
        a_valid = 1; a_rd = 4'd7; a_data = 16'h7777;
        #1;
        chk("r7_rsv_ready", rsv_ready, 1);
        chk("r7_a_ready", a_ready, 1);
        tick();
        rsv_valid = 0; a_valid = 0;
        chk("r7_set_wins", busy, 16'h00C0);
        chk("r7_err_still", err, 1);

        // Reset mid-operation
        reserve(4'd1);
        reserve(4'd2);
        reserve(4'd4);
        reserve(4'd5);
        chk("pre_rst_busy", busy, 16'h00F6);
        a_valid = 1; a_rd = 4'd1; a_data = 16'hC0DE;
        tick();
        RST = 1;
        a_rd = 4'd4; a_data = 16'h0404;
        b_valid = 1; b_rd = 4'd2; b_data = 16'h0202;
        rsv_valid = 1; rsv_rd = 4'd3;
        q_rs = 4'd2;
        #1;
        chk("rstmid_regwre", RegWre, 1);
        chk("rstmid_rd", rd, 1);
        chk("rstmid_a", a_ready, 0);
        chk("rstmid_b", b_ready, 0);
        chk("rstmid_rsv", rsv_ready, 0);
        chk("rstmid_stall", q_stall, 0);
        tick();
        chk("rstpost_busy", busy, 16'h0000);
        chk("rstpost_regwre", RegWre, 0);
        chk("rstpost_rd", rd, 0);
        chk("rstpost_data", WriteData, 0);
        chk("rstpost_err", err, 0);
        RST = 0;
        rsv_valid = 0;
        #1;
        chk("rstpost_pri_a", a_ready, 1);
        chk("rstpost_pri_b", b_ready, 0);
        a_valid = 0; b_valid = 0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
